// File: rtl/systolic_array_ctrl.sv
// Sequencer for the 8-bit systolic array: skews input vectors into the array and de-skews
// the bottom-row stream into aligned results. Optional counters under SA_CTRL_PERF_EN.
module systolic_array_ctrl #(
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned NUM_COLS = 8,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NUM_COLS-1:0] in_data,
  output logic                  arr_clear,
  output logic [8*NUM_COLS-1:0] arr_in,
  input  logic [8*NUM_COLS-1:0] arr_out,
  output logic                  out_valid,
  output logic [8*NUM_COLS-1:0] out_data,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_bubbles
);

  localparam int unsigned Lat = NUM_ROWS + NUM_COLS;

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] feed_cnt_q;
  logic [Lat-1:0]   tag_q;
  logic             fire;
  logic             start_acc;

  assign fire      = in_valid & in_ready;
  assign start_acc = (state_q == StIdle) & start;
  assign arr_clear = start_acc & (cfg_len != '0);
  assign out_valid = tag_q[Lat-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      feed_cnt_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (cfg_len != '0) begin
              len_q      <= cfg_len;
              feed_cnt_q <= '0;
              in_ready   <= 1'b1;
              state_q    <= StFeed;
            end else begin
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StFeed: begin
          if (fire) begin
            feed_cnt_q <= feed_cnt_q + LEN_W'(1);
            // Compare against len-1 so a full-range length never needs the counter to wrap.
            if (feed_cnt_q == len_q - LEN_W'(1)) begin
              in_ready <= 1'b0;
              state_q  <= StDrain;
            end
          end
        end
        StDrain: begin
          if (tag_q == '0) begin
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[Lat-2:0], fire};
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
    localparam int unsigned DeskewDepth = NUM_COLS - 1 - c;

    logic [7:0] lane_in;
    logic [7:0] aligned;
    logic [7:0] out_lane_q;

    // Bubbles inject zeros so the array keeps running without a stall.
    assign lane_in = fire ? in_data[8*c +: 8] : 8'd0;

    if (c == 0) begin : g_direct
      assign arr_in[7:0] = lane_in;
    end else begin : g_skew
      logic [7:0] skew_q [c];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < c; i++) skew_q[i] <= '0;
        end else begin
          skew_q[0] <= lane_in;
          for (int i = 1; i < c; i++) skew_q[i] <= skew_q[i-1];
        end
      end
      assign arr_in[8*c +: 8] = skew_q[c-1];
    end

    if (DeskewDepth == 0) begin : g_nodeskew
      assign aligned = arr_out[8*c +: 8];
    end else begin : g_deskew
      logic [7:0] deskew_q [DeskewDepth];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(DeskewDepth); i++) deskew_q[i] <= '0;
        end else begin
          deskew_q[0] <= arr_out[8*c +: 8];
          for (int i = 1; i < int'(DeskewDepth); i++) deskew_q[i] <= deskew_q[i-1];
        end
      end
      assign aligned = deskew_q[DeskewDepth-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_lane_q <= '0;
      end else begin
        out_lane_q <= aligned;
      end
    end
    assign out_data[8*c +: 8] = out_lane_q;
  end

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_bubbles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q  <= '0;
      perf_bubbles_q <= '0;
    end else if (start_acc) begin
      perf_cycles_q  <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == StFeed) && !fire && (perf_bubbles_q != '1)) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  assign perf_cycles  = 32'd0;
  assign perf_bubbles = 32'd0;
`endif

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencer for the 8-bit systolic array; one tile = `cfg_len` input vectors, each `NUM_COLS` lanes wide.
- Accepts vectors over a valid/ready handshake and skews them into the array (lane c delayed c cycles).
- De-skews the array's bottom-row output stream (lane c delayed `NUM_COLS-1-c` cycles) and presents aligned result vectors with a valid flag.
- Sits between the tile buffer / DMA and the array instance. Owns start/busy/done and the array clear pulse.

Parameters:
- `NUM_ROWS`, 8, array rows; sets array pipeline depth.
- `NUM_COLS`, 8, array columns; lanes per vector.
- `LEN_W`, 8, width of the tile-length field.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  pulse; begins a tile when idle.
- `cfg_len`  in  `LEN_W`  vectors per tile; sampled when `start` is accepted.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle pulse after the last result is emitted.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  controller accepts a vector this cycle.
- `in_data`  in  `8*NUM_COLS`  input vector; lane c is bits [8c+7:8c].
- `arr_clear`  out  1  one-cycle clear to the array, asserted on the start cycle.
- `arr_in`  out  `8*NUM_COLS`  skewed vector, drives the array's `input_stream`.
- `arr_out`  in  `8*NUM_COLS`  array `output_stream`.
- `out_valid`  out  1  aligned result valid.
- `out_data`  out  `8*NUM_COLS`  aligned result vector (registered).
- `perf_cycles`  out  32  see Optional Feature.
- `perf_bubbles`  out  32  see Optional Feature.

Behaviour:
- Reset values: `busy`, `done`, `in_ready`, `arr_clear`, `out_valid` = 0. `arr_in`, `out_data`, `perf_*` = 0. All skew, deskew and tag registers = 0. FSM = IDLE.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 with `cfg_len`≠0: latch `cfg_len`, pulse `arr_clear`, set `busy`, go to FEED.
  - `start`=1 with `cfg_len`=0: go to DONE; `busy` is high for that one cycle only.
- FEED:
  - `in_ready`=1.
  - A vector is accepted when `in_valid`&`in_ready`; acceptance increments `feed_cnt`.
  - A cycle without acceptance injects an all-zero vector with tag 0 (bubble). The array never stalls.
  - When `feed_cnt` reaches the latched length, `in_ready` drops the next cycle and the FSM goes to DRAIN.
- DRAIN:
  - `in_ready`=0; zero vectors are injected.
  - Leave for DONE when the tag pipeline holds no set bits and the final `out_valid` has been emitted.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `start` while `busy` is ignored.
- Skew: lane c passes through c registers before `arr_in`; lane 0 is combinationally muxed (data or 0).
- Array latency: `NUM_ROWS` cycles. Deskew: lane c of `arr_out` passes through `NUM_COLS-1-c` registers, then the `out_data` register.
- Total latency L = `NUM_ROWS`+`NUM_COLS` cycles from the acceptance edge to `out_valid`, identical for every lane.
- A one-bit tag shift register of depth L tracks accepted vectors; its output drives `out_valid`.
- Bubbles produce no `out_valid`. Output ordering equals input ordering.
- There is no output backpressure: the consumer must accept every `out_valid` cycle.
- The array is treated as a fixed-latency pipe. Lane arithmetic is passthrough, 8 bits, no width growth in this block.
- Reset mid-tile: the asynchronous clear returns all state to reset values immediately. No `done` is generated for the aborted tile.
- `cfg_len` = 2^`LEN_W`-1 is legal. `feed_cnt` is `LEN_W` bits and must not wrap before the compare.

Optional Feature:
- Macro: `SA_CTRL_PERF_EN`.
- Defined:
  - `perf_cycles` counts cycles with `busy`=1 in the current tile.
  - `perf_bubbles` counts FEED cycles without acceptance.
  - Both clear on start acceptance, hold after `done`, and saturate at 2^32-1.
- Undefined: both ports are driven constant 0 and no counter registers are built.

Test Plan (`NUM_ROWS`=`NUM_COLS`=4, L=8, array modelled as an ideal 4-cycle delay):
1. `cfg_len`=3, `in_valid` held high, vectors 0x04030201 / 0x08070605 / 0x0C0B0A09 -> `arr_in` lane c shows each byte c cycles late. `out_valid` on 3 consecutive cycles starting 8 cycles after the first accept, same three values in order. `done` pulses once, then `busy`=0.
2. `cfg_len`=4, `in_valid` low on alternating cycles -> `out_valid` pattern mirrors the accept pattern shifted 8 cycles, data intact. With `SA_CTRL_PERF_EN`, `perf_bubbles`=3.
3. `cfg_len`=0, `start` pulse -> `done` pulses on the cycle after start, no `arr_clear`, no `out_valid`, `in_ready` stays 0.
4. `start` re-pulsed during FEED with `cfg_len`=9 -> ignored: tile length stays at the original value and exactly the original count of results appear.
5. `reset` asserted asynchronously mid-DRAIN -> all outputs 0 the same cycle, no `out_valid` and no `done` after release. A following tile with `cfg_len`=1 runs normally with L=8.
6. `cfg_len`=255, continuous input -> 255 `out_valid` cycles back-to-back, no counter wrap. With `SA_CTRL_PERF_EN`, `perf_cycles` = 255+8+2 ±1 per FSM timing.
